// File: rtl/game_pkg.sv
// Shared types and helpers for the number-guessing game.
// States, difficulty levels, digit counts and BCD conversion.
package game_pkg;

    localparam int LFSR_W = 12;

    // Feedback taps for x^12 + x^6 + x^4 + x + 1 (bits 11, 5, 3, 0)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 12'h829;

    localparam logic [1:0] DIGITS_EASY = 2'd1;
    localparam logic [1:0] DIGITS_MED  = 2'd2;
    localparam logic [1:0] DIGITS_HARD = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        PLAY,
        CHECK,
        WIN,
        LOSE
    } state_e;

    typedef enum logic [1:0] {
        DIFF_EASY,
        DIFF_MED,
        DIFF_HARD,
        DIFF_HARD_ALT
    } diff_e;

    // Weighted value of three BCD digits, truncated to 10 bits
    function automatic logic [9:0] bcd_to_val(
        input logic [3:0] d3,
        input logic [3:0] d2,
        input logic [3:0] d1
    );
        return 10'(d3) * 10'd100 + 10'(d2) * 10'd10 + 10'(d1);
    endfunction

    // Fold a raw nibble into a decimal digit (10..15 -> 4..9)
    function automatic logic [3:0] nib_to_digit(input logic [3:0] n);
        return (n > 4'd9) ? n - 4'd6 : n;
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// 12-bit Fibonacci LFSR, free-running, shifting left.
// The raw register is exposed so the caller picks nibbles.
module game_lfsr
    import game_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 12'hACE
) (
    input  logic              clk_i,
    input  logic              reset_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic              fb;

    // Next value: parity of the tapped bits shifted in at bit 0
    always_comb begin
        fb     = ^(lfsr_q & LFSR_TAPS);
        lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
    end

    // Advance every cycle; reset reloads the seed
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/game_controller.sv
// Number-guessing game sequencer: secret draw, guess budget, compare.
// Define GAME_HINT_EN to build the higher/lower hint outputs.
module game_controller
    import game_pkg::*;
#(
    parameter logic [11:0] LFSR_SEED    = 12'hACE,
    parameter logic [2:0]  EASY_GUESSES = 3'd5,
    parameter logic [2:0]  MED_GUESSES  = 3'd6,
    parameter logic [2:0]  HARD_GUESSES = 3'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] difficulty,
    input  logic       confirm,
    input  logic [3:0] guess_digit_1,
    input  logic [3:0] guess_digit_2,
    input  logic [3:0] guess_digit_3,
    output logic [1:0] max_digits,
    output logic [2:0] max_guesses,
    output logic [3:0] secret_digit_1,
    output logic [3:0] secret_digit_2,
    output logic [3:0] secret_digit_3,
    output logic [2:0] guesses_left,
    output logic       playing,
    output logic       won,
    output logic       lost,
    output logic       hint_higher,
    output logic       hint_lower
);

    state_e      state_q, state_d;
    diff_e       diff_q, diff_d;
    logic [1:0]  digits_q, digits_d;
    logic [2:0]  budget_q, budget_d;
    logic [2:0]  left_q, left_d;
    logic [3:0]  sec1_q, sec1_d;
    logic [3:0]  sec2_q, sec2_d;
    logic [3:0]  sec3_q, sec3_d;

    logic [11:0] lfsr;
    logic [1:0]  cfg_digits;
    logic [2:0]  cfg_budget;
    logic [3:0]  g1, g2, g3;
    logic [9:0]  guess_val;
    logic [9:0]  secret_val;
    logic        guess_match;

    game_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk_i  (clk),
        .reset_i(reset),
        .state_o(lfsr)
    );

    // Difficulty level to digit count and guess budget
    always_comb begin
        cfg_digits = DIGITS_HARD;
        cfg_budget = HARD_GUESSES;
        unique case (diff_q)
            DIFF_EASY: begin
                cfg_digits = DIGITS_EASY;
                cfg_budget = EASY_GUESSES;
            end
            DIFF_MED: begin
                cfg_digits = DIGITS_MED;
                cfg_budget = MED_GUESSES;
            end
            default: begin
                cfg_digits = DIGITS_HARD;
                cfg_budget = HARD_GUESSES;
            end
        endcase
    end

    // Mask unused guess digits and form both compare operands
    always_comb begin
        g1 = guess_digit_1;
        g2 = (digits_q >= DIGITS_MED) ? guess_digit_2 : 4'd0;
        g3 = (digits_q >= DIGITS_HARD) ? guess_digit_3 : 4'd0;
        guess_val   = bcd_to_val(g3, g2, g1);
        secret_val  = bcd_to_val(sec3_q, sec2_q, sec1_q);
        guess_match = (guess_val == secret_val);
    end

    // Next-state and datapath updates for the game FSM
    always_comb begin
        state_d  = state_q;
        diff_d   = diff_q;
        digits_d = digits_q;
        budget_d = budget_q;
        left_d   = left_q;
        sec1_d   = sec1_q;
        sec2_d   = sec2_q;
        sec3_d   = sec3_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    diff_d  = diff_e'(difficulty);
                    state_d = SEED;
                end
            end
            SEED: begin
                digits_d = cfg_digits;
                budget_d = cfg_budget;
                left_d   = cfg_budget;
                sec1_d   = nib_to_digit(lfsr[3:0]);
                sec2_d   = (cfg_digits >= DIGITS_MED)
                         ? nib_to_digit(lfsr[7:4]) : 4'd0;
                sec3_d   = (cfg_digits >= DIGITS_HARD)
                         ? nib_to_digit(lfsr[11:8]) : 4'd0;
                state_d  = PLAY;
            end
            PLAY: begin
                if (confirm) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (left_q != 3'd0) begin
                    left_d = left_q - 3'd1;
                end
                if (guess_match) begin
                    state_d = WIN;
                end else if (left_q <= 3'd1) begin
                    state_d = LOSE;
                end else begin
                    state_d = PLAY;
                end
            end
            WIN, LOSE: begin
                if (start) begin
                    diff_d  = diff_e'(difficulty);
                    state_d = SEED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            diff_q   <= DIFF_EASY;
            digits_q <= DIGITS_EASY;
            budget_q <= EASY_GUESSES;
            left_q   <= 3'd0;
            sec1_q   <= 4'd0;
            sec2_q   <= 4'd0;
            sec3_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            diff_q   <= diff_d;
            digits_q <= digits_d;
            budget_q <= budget_d;
            left_q   <= left_d;
            sec1_q   <= sec1_d;
            sec2_q   <= sec2_d;
            sec3_q   <= sec3_d;
        end
    end

`ifdef GAME_HINT_EN
    logic hint_hi_q;
    logic hint_lo_q;

    // Hints: cleared on a new game, set by a wrong guess that continues play
    always_ff @(posedge clk) begin
        if (reset) begin
            hint_hi_q <= 1'b0;
            hint_lo_q <= 1'b0;
        end else if (state_q == SEED) begin
            hint_hi_q <= 1'b0;
            hint_lo_q <= 1'b0;
        end else if (state_q == CHECK && !guess_match && left_q > 3'd1) begin
            hint_hi_q <= (secret_val > guess_val);
            hint_lo_q <= (secret_val < guess_val);
        end
    end

    assign hint_higher = hint_hi_q;
    assign hint_lower  = hint_lo_q;
`else
    assign hint_higher = 1'b0;
    assign hint_lower  = 1'b0;
`endif

    assign max_digits     = digits_q;
    assign max_guesses    = budget_q;
    assign secret_digit_1 = sec1_q;
    assign secret_digit_2 = sec2_q;
    assign secret_digit_3 = sec3_q;
    assign guesses_left   = left_q;
    assign playing        = (state_q == PLAY) || (state_q == CHECK);
    assign won            = (state_q == WIN);
    assign lost           = (state_q == LOSE);

endmodule
